// File: rtl/vend_controller_if.sv
// Coin-slot / actuator bundle between the vending front end and vend_controller.
// The front end is the master: it drives the customer and hopper inputs and observes the controller outputs.
interface vend_controller_if #(
  parameter int CREDIT_W = 8
);
  logic                coin_valid;
  logic [1:0]          coin_type;
  logic                vend_req;
  logic                cancel;
  logic                chg_ready;
  logic [CREDIT_W-1:0] credit;
  logic                item_out;
  logic                chg_valid;
  logic [1:0]          chg_type;
  logic                coin_reject;
  logic                low_credit;
  logic                busy;

  modport master (
    output coin_valid, coin_type, vend_req, cancel, chg_ready,
    input  credit, item_out, chg_valid, chg_type, coin_reject, low_credit, busy
  );

  modport slave (
    input  coin_valid, coin_type, vend_req, cancel, chg_ready,
    output credit, item_out, chg_valid, chg_type, coin_reject, low_credit, busy
  );
endinterface

// File: rtl/vend_controller.sv
// Vending machine sequencer: coin acceptance, credit accumulation, item release and
// one-coin-at-a-time change return. All flops run on the falling edge of CLKb.
module vend_controller #(
  parameter int PRICE       = 75,
  parameter int MAX_CREDIT  = 200,
  parameter int CREDIT_W    = 8,
  parameter int VEND_CYCLES = 2
) (
  input  logic              CLKb,
  input  logic              RSTb,
  vend_controller_if.slave  bus
);

  localparam int CNT_W = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(VEND_CYCLES - 1);
  localparam logic [CREDIT_W:0] PRICE_W  = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0] MAX_W    = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0] C5       = (CREDIT_W+1)'(5);
  localparam logic [CREDIT_W:0] C10      = (CREDIT_W+1)'(10);
  localparam logic [CREDIT_W:0] C25      = (CREDIT_W+1)'(25);
  localparam logic [CREDIT_W:0] ZERO_W   = '0;

  typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W:0]   credit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                item_q, item_d;
  logic                chg_valid_q, chg_valid_d;
  logic [1:0]          chg_type_q, chg_type_d;
  logic                reject_q, reject_d;
  logic                low_q, low_d;
  logic                busy_q, busy_d;
  logic [CREDIT_W:0]   credit_w;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;

  function automatic logic [CREDIT_W:0] coin_cents(input logic [1:0] t);
    case (t)
      2'b00:   return C5;
      2'b01:   return C10;
      2'b10:   return C25;
      default: return ZERO_W;
    endcase
  endfunction

  function automatic logic [1:0] greedy_coin(input logic [CREDIT_W:0] c);
    if (c >= C25)      return 2'b10;
    else if (c >= C10) return 2'b01;
    else               return 2'b00;
  endfunction

  assign credit_w = {1'b0, credit_q};
  assign coin_sum = credit_w + coin_cents(bus.coin_type);
  assign coin_ok  = (bus.coin_type != 2'b11) && (coin_sum <= MAX_W);

  always_comb begin
    state_d  = state_q;
    credit_d = credit_w;
    cnt_d    = cnt_q;
    item_d   = 1'b0;
    reject_d = 1'b0;
    low_d    = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        // A coin arriving alongside cancel or vend_req is always handed back.
        if (bus.cancel) begin
          reject_d = bus.coin_valid;
          if (credit_w != ZERO_W) state_d = CHANGE;
        end else if (bus.vend_req) begin
          reject_d = bus.coin_valid;
          if (credit_w >= PRICE_W) begin
            state_d  = VEND;
            credit_d = credit_w - PRICE_W;
            cnt_d    = '0;
            item_d   = 1'b1;
          end else begin
            low_d = 1'b1;
          end
        end else if (bus.coin_valid) begin
          if (coin_ok) begin
            credit_d = coin_sum;
            state_d  = ACCUM;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      VEND: begin
        reject_d = bus.coin_valid;
        if (cnt_q == CNT_LAST) begin
          state_d = (credit_w != ZERO_W) ? CHANGE : IDLE;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          item_d = 1'b1;
        end
      end
      CHANGE: begin
        reject_d = bus.coin_valid;
        if (bus.chg_ready) begin
          credit_d = credit_w - coin_cents(chg_type_q);
          if (credit_d == ZERO_W) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    chg_valid_d = (state_d == CHANGE);
    chg_type_d  = chg_valid_d ? greedy_coin(credit_d) : 2'b00;
    busy_d      = (state_d == VEND) || (state_d == CHANGE);
  end

  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      cnt_q       <= '0;
      item_q      <= 1'b0;
      chg_valid_q <= 1'b0;
      chg_type_q  <= 2'b00;
      reject_q    <= 1'b0;
      low_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d[CREDIT_W-1:0];
      cnt_q       <= cnt_d;
      item_q      <= item_d;
      chg_valid_q <= chg_valid_d;
      chg_type_q  <= chg_type_d;
      reject_q    <= reject_d;
      low_q       <= low_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.credit      = credit_q;
  assign bus.item_out    = item_q;
  assign bus.chg_valid   = chg_valid_q;
  assign bus.chg_type    = chg_type_q;
  assign bus.coin_reject = reject_q;
  assign bus.low_credit  = low_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: a transaction-level model of credit, vending
// and refunding is compared against every output on each rising (inactive) edge.
module tb_vend_controller;

  localparam int PRICE       = 75;
  localparam int MAX_CREDIT  = 200;
  localparam int CREDIT_W    = 8;
  localparam int VEND_CYCLES = 2;

  logic CLKb = 1'b1;
  logic RSTb = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  int m_credit    = 0;
  int m_vend_left = 0;
  bit m_refund    = 0;
  bit e_reject    = 0;
  bit e_low       = 0;

  vend_controller_if #(.CREDIT_W(CREDIT_W)) bus ();

  vend_controller #(
    .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .CREDIT_W(CREDIT_W), .VEND_CYCLES(VEND_CYCLES)
  ) dut (
    .CLKb(CLKb),
    .RSTb(RSTb),
    .bus(bus)
  );

  always #5 CLKb = ~CLKb;

  function automatic int coin_value(input int t);
    case (t)
      0:       return 5;
      1:       return 10;
      2:       return 25;
      default: return 0;
    endcase
  endfunction

  function automatic int refund_code(input int c);
    if (c >= 25) return 2;
    if (c >= 10) return 1;
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_credit    = 0;
    m_vend_left = 0;
    m_refund    = 0;
    e_reject    = 0;
    e_low       = 0;
  endtask

  // One machine step as the customer sees it: dispensing, refunding, or taking requests.
  task automatic model_step();
    int val;
    if (!RSTb) begin
      model_reset();
      return;
    end
    e_reject = 0;
    e_low    = 0;
    if (m_vend_left > 0) begin
      e_reject = bus.coin_valid;
      m_vend_left--;
      if (m_vend_left == 0 && m_credit > 0) m_refund = 1;
    end else if (m_refund) begin
      e_reject = bus.coin_valid;
      if (bus.chg_ready) begin
        m_credit -= coin_value(refund_code(m_credit));
        if (m_credit == 0) m_refund = 0;
      end
    end else if (bus.cancel) begin
      e_reject = bus.coin_valid;
      if (m_credit > 0) m_refund = 1;
    end else if (bus.vend_req) begin
      e_reject = bus.coin_valid;
      if (m_credit >= PRICE) begin
        m_credit   -= PRICE;
        m_vend_left = VEND_CYCLES;
      end else begin
        e_low = 1;
      end
    end else if (bus.coin_valid) begin
      val = coin_value(int'(bus.coin_type));
      if (bus.coin_type != 2'b11 && m_credit + val <= MAX_CREDIT) m_credit += val;
      else e_reject = 1;
    end
  endtask

  always @(posedge CLKb) begin
    checkOutput("credit",      bus.credit,      m_credit);
    checkOutput("item_out",    bus.item_out,    m_vend_left > 0);
    checkOutput("chg_valid",   bus.chg_valid,   m_refund);
    checkOutput("chg_type",    bus.chg_type,    m_refund ? refund_code(m_credit) : 0);
    checkOutput("coin_reject", bus.coin_reject, e_reject);
    checkOutput("low_credit",  bus.low_credit,  e_low);
    checkOutput("busy",        bus.busy,        (m_vend_left > 0) || m_refund);
  end

  task automatic applyStimulus(input bit cv, input int ct, input bit vr, input bit cn, input bit cr);
    bus.coin_valid = cv;
    bus.coin_type  = 2'(ct);
    bus.vend_req   = vr;
    bus.cancel     = cn;
    bus.chg_ready  = cr;
    @(negedge CLKb);
    model_step();
    @(posedge CLKb);
    #1;
  endtask

  task automatic coin(input int ct);
    applyStimulus(1, ct, 0, 0, 0);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (m_refund || m_vend_left > 0); i++) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("drain_busy", bus.busy, 0);
    checkOutput("drain_credit", bus.credit, 0);
  endtask

  initial begin
    bus.coin_valid = 0; bus.coin_type = 2'b00; bus.vend_req = 0; bus.cancel = 0; bus.chg_ready = 0;
    #1;
    checkOutput("reset_credit", bus.credit, 0);
    checkOutput("reset_busy", bus.busy, 0);
    @(posedge CLKb); #1;
    RSTb = 1'b1;

    $display("[TB] exact price vend");
    coin(2); checkOutput("t1_credit25", bus.credit, 25);
    coin(2); checkOutput("t1_credit50", bus.credit, 50);
    coin(2); checkOutput("t1_credit75", bus.credit, 75);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t1_credit0", bus.credit, 0);
    checkOutput("t1_busy", bus.busy, 1);
    checkOutput("t1_item1", bus.item_out, 1);
    idle(); checkOutput("t1_item2", bus.item_out, 1);
    idle(); checkOutput("t1_item_off", bus.item_out, 0);
    checkOutput("t1_no_chg", bus.chg_valid, 0);
    checkOutput("t1_idle", bus.busy, 0);

    $display("[TB] vend with change");
    repeat (4) coin(2);
    checkOutput("t2_credit100", bus.credit, 100);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t2_credit25", bus.credit, 25);
    idle(); idle();
    checkOutput("t2_chg_valid", bus.chg_valid, 1);
    checkOutput("t2_chg_type", bus.chg_type, 2);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t2_credit0", bus.credit, 0);
    checkOutput("t2_chg_drop", bus.chg_valid, 0);

    $display("[TB] cancel with stalled hopper");
    coin(1); coin(0); coin(2);
    checkOutput("t3_credit40", bus.credit, 40);
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      checkOutput("t3_hold_valid", bus.chg_valid, 1);
      checkOutput("t3_hold_type", bus.chg_type, 2);
      checkOutput("t3_hold_credit", bus.credit, 40);
      applyStimulus(0, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t3_after25", bus.credit, 15);
    checkOutput("t3_type10", bus.chg_type, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t3_after10", bus.credit, 5);
    checkOutput("t3_type5", bus.chg_type, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t3_done", bus.chg_valid, 0);

    $display("[TB] coin rejection");
    repeat (7) coin(2);
    coin(1); coin(1);
    checkOutput("t4_credit195", bus.credit, 195);
    coin(2);
    checkOutput("t4_over_reject", bus.coin_reject, 1);
    checkOutput("t4_hold195", bus.credit, 195);
    idle(); checkOutput("t4_reject_pulse", bus.coin_reject, 0);
    coin(3);
    checkOutput("t4_slug_reject", bus.coin_reject, 1);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t4_credit120", bus.credit, 120);
    coin(0);
    checkOutput("t4_vend_reject", bus.coin_reject, 1);
    checkOutput("t4_vend_credit", bus.credit, 120);
    drain();

    $display("[TB] low credit and cancel priority");
    coin(2); coin(2);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t5_low", bus.low_credit, 1);
    checkOutput("t5_credit50", bus.credit, 50);
    checkOutput("t5_not_busy", bus.busy, 0);
    idle(); checkOutput("t5_low_pulse", bus.low_credit, 0);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("t5_refund", bus.chg_valid, 1);
    checkOutput("t5_no_item", bus.item_out, 0);
    drain();

    $display("[TB] reset during change");
    coin(2); coin(1);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t6_mid_credit", bus.credit, 10);
    checkOutput("t6_mid_type", bus.chg_type, 1);
    RSTb = 1'b0;
    #1;
    model_reset();
    checkOutput("t6_rst_credit", bus.credit, 0);
    checkOutput("t6_rst_item", bus.item_out, 0);
    checkOutput("t6_rst_chg_valid", bus.chg_valid, 0);
    checkOutput("t6_rst_chg_type", bus.chg_type, 0);
    checkOutput("t6_rst_reject", bus.coin_reject, 0);
    checkOutput("t6_rst_low", bus.low_credit, 0);
    checkOutput("t6_rst_busy", bus.busy, 0);
    applyStimulus(0, 0, 0, 0, 1);
    RSTb = 1'b1;
    idle();
    checkOutput("t6_post_credit", bus.credit, 0);
    checkOutput("t6_post_busy", bus.busy, 0);
    coin(0);
    checkOutput("t6_post_coin", bus.credit, 5);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
